genius_seq_player: RTL and testbench
====================================

// Module: genius_seq_player
// PURPOSE
//  Consumer side of the random-number generator: captures generated values as game colours into a
//  sequence memory, plays the stored sequence back to the LED driver, then checks player presses.
//  Sits between the RNG and the Genius top-level game FSM; the game FSM drives append/start/clear.
// PARAMETERS
//  DATA_WIDTH   8   width of random word from the generator (rnd_i)
//  COLOR_W      2   bits per colour; colour = rnd_i[COLOR_W-1:0] (4 colours)
//  MAX_LEN      32  sequence memory depth (max round length)
//  STEP_CYCLES  4   clocks a colour is lit, and clocks of the dark gap after it (>=1)
//  TIMEOUT_CYC  64  press timeout in CHECK (used only with GENIUS_TIMEOUT_EN)
// PORTS
//  clk            in   1                      rising-edge clock
//  rst_n          in   1                      asynchronous active-low reset
//  rnd_i          in   DATA_WIDTH             random word from generator
//  append_i       in   1                      store rnd_i colour at end of sequence
//  clear_i        in   1                      empty sequence, abort any round
//  start_i        in   1                      start round: playback then check
//  press_valid_i  in   1                      one-cycle strobe, player pressed a button
//  press_color_i  in   COLOR_W                colour pressed
//  color_o        out  COLOR_W                colour being shown
//  color_valid_o  out  1                      LED on for color_o
//  busy_o         out  1                      state != IDLE
//  checking_o     out  1                      state == CHECK
//  round_ok_o     out  1                      1-cycle pulse: whole sequence matched
//  error_o        out  1                      1-cycle pulse: wrong press or timeout
//  timeout_o      out  1                      1-cycle pulse, coincident with error_o on timeout
//  len_o          out  $clog2(MAX_LEN+1)      stored sequence length
//  full_o         out  1                      len_o == MAX_LEN
// BEHAVIOUR
//  - Reset: state IDLE, len 0, idx 0, timer 0; all outputs 0. Memory contents undefined (no reset).
//  - Priority per cycle: clear_i > start_i > append_i. All outputs registered.
//  - clear_i: any state -> IDLE, len/idx/timer 0 next cycle; pulses not generated.
//  - append_i: accepted only in IDLE and !full; mem[len] <= rnd_i[COLOR_W-1:0], len+1 next cycle.
//    Ignored when full or busy (no error). append with start same cycle: start wins, append dropped.
//  - start_i in IDLE with len>0: next cycle PLAY_ON, idx 0. start_i with len==0 or when busy: ignored.
//  - PLAY_ON: color_valid_o=1, color_o=mem[idx] for STEP_CYCLES clocks -> PLAY_OFF.
//  - PLAY_OFF: color_valid_o=0 for STEP_CYCLES clocks; then idx==len-1 -> CHECK (idx 0),
//    else idx+1 -> PLAY_ON. Presses outside CHECK ignored.
//  - CHECK: on press_valid_i compare press_color_i with mem[idx]:
//    match, idx<len-1 -> idx+1, stay; match, idx==len-1 -> round_ok_o pulse next cycle, IDLE;
//    mismatch -> error_o pulse next cycle, IDLE. len kept in both cases (game FSM appends/clears).
//  - Timer counts 0..STEP_CYCLES-1 in PLAY states; wraps to 0 on each state change.
//  - Round length 1 and MAX_LEN both valid; idx width = $clog2(MAX_LEN), never exceeds len-1.
// CONFIGURATION
//  GENIUS_TIMEOUT_EN defined: in CHECK, counter reset on each press; reaching TIMEOUT_CYC clocks
//    without press -> error_o and timeout_o pulse next cycle, IDLE. Press on the expiring cycle wins.
//  Not defined: CHECK waits indefinitely; timeout_o tied 0; no timeout counter synthesised.
// STRUCTURE
//  - genius_pkg: color_t (logic [COLOR_W-1:0]), state_e {IDLE, PLAY_ON, PLAY_OFF, CHECK}.
//  - Sub-module genius_step_timer: load/run counter, terminal-count flag; reused for timeout.
//  - Memory: plain register array, one write port, one async read port at idx.
// TESTING
//  - Reset mid-PLAY_ON (rst_n low 1 cycle) -> all outputs 0 immediately, len_o 0.
//  - Append rnd 8'h05,8'hA2,8'h13 -> len_o 3; start -> colours 1,2,3, each 4 on / 4 off; CHECK after 24 clocks.
//  - In CHECK press 1,2,3 -> round_ok_o one pulse after third press, busy_o 0.
//  - Press 1,3 -> error_o pulse after second press, IDLE, len_o still 3.
//  - 33 appends with MAX_LEN 32 -> len_o 32, full_o 1, mem[31] holds 32nd value; start with len 0 ignored.
//  - clear_i during CHECK -> IDLE, len_o 0, no pulses; GENIUS_TIMEOUT_EN: 64 idle clocks -> error_o+timeout_o.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared types for the Genius sequence player: colour word and FSM state encoding.
package genius_pkg;

    localparam int GENIUS_COLOR_W = 2;

    typedef logic [GENIUS_COLOR_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE,
        PLAY_ON,
        PLAY_OFF,
        CHECK
    } state_e;

endpackage

// File: rtl/genius_step_timer.sv
// Load/run counter with a terminal-count flag; paces LED steps and, optionally, the press timeout.
module genius_step_timer #(
    parameter int TC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic tc
);

    localparam int W = (TC > 1) ? $clog2(TC) : 1;

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (run) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign tc = run && (count_reg == W'(TC - 1));

endmodule

// File: rtl/genius_seq_player.sv
// Stores RNG colours, plays the sequence to the LEDs, then checks player presses.
// Optional press timeout in CHECK is enabled by defining GENIUS_TIMEOUT_EN.
module genius_seq_player
    import genius_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COLOR_W     = 2,
    parameter int MAX_LEN     = 32,
    parameter int STEP_CYCLES = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_WIDTH-1:0]        rnd_i,
    input  logic                         append_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic                         press_valid_i,
    input  logic [COLOR_W-1:0]           press_color_i,
    output logic [COLOR_W-1:0]           color_o,
    output logic                         color_valid_o,
    output logic                         busy_o,
    output logic                         checking_o,
    output logic                         round_ok_o,
    output logic                         error_o,
    output logic                         timeout_o,
    output logic [$clog2(MAX_LEN+1)-1:0] len_o,
    output logic                         full_o
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e             state_reg;
    logic [LEN_W-1:0]   len_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               full_reg;
    logic [COLOR_W-1:0] color_reg;
    logic               color_valid_reg;
    logic               busy_reg;
    logic               checking_reg;
    logic               round_ok_reg;
    logic               error_reg;
    logic               timeout_reg;

    logic [COLOR_W-1:0] mem [MAX_LEN];

    logic play_active;
    logic step_tc;
    logic idx_last;
    logic append_ok;
    logic timeout_tc;
    logic unused_rnd_bits;

    assign unused_rnd_bits = &{1'b0, rnd_i[DATA_WIDTH-1:COLOR_W]};

    if (STEP_CYCLES < 1 || TIMEOUT_CYC < 1) begin : g_param_out_of_range
    end

    assign play_active = (state_reg == PLAY_ON) || (state_reg == PLAY_OFF);
    assign idx_last    = (LEN_W'(idx_reg) == len_reg - LEN_W'(1));
    assign append_ok   = append_i && !clear_i && !start_i && (state_reg == IDLE) && !full_reg;

    genius_step_timer #(.TC(STEP_CYCLES)) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (clear_i || !play_active || step_tc),
        .run   (play_active),
        .tc    (step_tc)
    );

`ifdef GENIUS_TIMEOUT_EN
    // Restarted by every press so the limit applies to the gap between presses
    genius_step_timer #(.TC(TIMEOUT_CYC)) u_timeout_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (clear_i || (state_reg != CHECK) || press_valid_i),
        .run   (state_reg == CHECK),
        .tc    (timeout_tc)
    );
    assign timeout_o = timeout_reg;
`else
    assign timeout_tc = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (append_ok) begin
            mem[len_reg[IDX_W-1:0]] <= rnd_i[COLOR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            idx_reg         <= '0;
            full_reg        <= 1'b0;
            color_reg       <= '0;
            color_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            checking_reg    <= 1'b0;
            round_ok_reg    <= 1'b0;
            error_reg       <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            round_ok_reg <= 1'b0;
            error_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            if (clear_i) begin
                state_reg       <= IDLE;
                len_reg         <= '0;
                idx_reg         <= '0;
                full_reg        <= 1'b0;
                color_reg       <= '0;
                color_valid_reg <= 1'b0;
                busy_reg        <= 1'b0;
                checking_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start_i) begin
                            if (len_reg != '0) begin
                                state_reg       <= PLAY_ON;
                                idx_reg         <= '0;
                                color_reg       <= mem[0];
                                color_valid_reg <= 1'b1;
                                busy_reg        <= 1'b1;
                            end
                        end else if (append_ok) begin
                            len_reg  <= len_reg + LEN_W'(1);
                            full_reg <= (len_reg + LEN_W'(1) == LEN_W'(MAX_LEN));
                        end
                    end
                    PLAY_ON: begin
                        if (step_tc) begin
                            state_reg       <= PLAY_OFF;
                            color_reg       <= '0;
                            color_valid_reg <= 1'b0;
                        end
                    end
                    PLAY_OFF: begin
                        if (step_tc) begin
                            if (idx_last) begin
                                state_reg    <= CHECK;
                                idx_reg      <= '0;
                                checking_reg <= 1'b1;
                            end else begin
                                state_reg       <= PLAY_ON;
                                idx_reg         <= idx_reg + IDX_W'(1);
                                color_reg       <= mem[idx_reg + IDX_W'(1)];
                                color_valid_reg <= 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        // A press on the expiring timeout cycle takes precedence
                        if (press_valid_i) begin
                            if (press_color_i == mem[idx_reg] && !idx_last) begin
                                idx_reg <= idx_reg + IDX_W'(1);
                            end else begin
                                round_ok_reg <= (press_color_i == mem[idx_reg]);
                                error_reg    <= (press_color_i != mem[idx_reg]);
                                state_reg    <= IDLE;
                                idx_reg      <= '0;
                                busy_reg     <= 1'b0;
                                checking_reg <= 1'b0;
                            end
                        end else if (timeout_tc) begin
                            error_reg    <= 1'b1;
                            timeout_reg  <= 1'b1;
                            state_reg    <= IDLE;
                            idx_reg      <= '0;
                            busy_reg     <= 1'b0;
                            checking_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign color_o       = color_reg;
    assign color_valid_o = color_valid_reg;
    assign busy_o        = busy_reg;
    assign checking_o    = checking_reg;
    assign round_ok_o    = round_ok_reg;
    assign error_o       = error_reg;
    assign len_o         = len_reg;
    assign full_o        = full_reg;

endmodule

// File: tb/tb_genius_seq_player.sv
// Self-checking bench for genius_seq_player: directed and randomized rounds against a queue model.
module tb_genius_seq_player;

    localparam int STEP    = 4;
    localparam int MAXL    = 32;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rnd_i = '0;
    logic       append_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       start_i = 1'b0;
    logic       press_valid_i = 1'b0;
    logic [1:0] press_color_i = '0;
    logic [1:0] color_o;
    logic       color_valid_o;
    logic       busy_o;
    logic       checking_o;
    logic       round_ok_o;
    logic       error_o;
    logic       timeout_o;
    logic [5:0] len_o;
    logic       full_o;

    int n_assert = 0;
    int n_fail   = 0;
    int seq_q[$];

    genius_seq_player dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rnd_i         (rnd_i),
        .append_i      (append_i),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .press_valid_i (press_valid_i),
        .press_color_i (press_color_i),
        .color_o       (color_o),
        .color_valid_o (color_valid_o),
        .busy_o        (busy_o),
        .checking_o    (checking_o),
        .round_ok_o    (round_ok_o),
        .error_o       (error_o),
        .timeout_o     (timeout_o),
        .len_o         (len_o),
        .full_o        (full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valid"}, color_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_checking"}, checking_o, 0);
        chk({tag, "_ok"}, round_ok_o, 0);
        chk({tag, "_err"}, error_o, 0);
        chk({tag, "_tmo"}, timeout_o, 0);
    endtask

    task automatic do_append(input logic [7:0] v);
        rnd_i = v;
        append_i = 1'b1;
        cyc();
        append_i = 1'b0;
        if (seq_q.size() < MAXL) seq_q.push_back(int'(v[1:0]));
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        seq_q.delete();
    endtask

    // Start a round and check the whole LED schedule: each colour STEP on, STEP off
    task automatic play_and_check(input bit junk_append);
        int n;
        bit on;
        n = seq_q.size();
        start_i = 1'b1;
        for (int k = 0; k < 2 * STEP * n; k++) begin
            if (junk_append && k > 0) begin
                append_i = 1'($urandom_range(0, 1));
                rnd_i = 8'($urandom);
            end
            cyc();
            start_i = 1'b0;
            on = (k % (2 * STEP)) < STEP;
            chk("play_valid", color_valid_o, on);
            if (on) chk("play_color", color_o, seq_q[k / (2 * STEP)]);
            chk("play_busy", busy_o, 1);
            chk("play_checking", checking_o, 0);
        end
        append_i = 1'b0;
        cyc();
        chk("enter_check", checking_o, 1);
        chk("check_valid", color_valid_o, 0);
        chk("play_len_kept", len_o, n);
    endtask

    task automatic do_press(input int c);
        press_valid_i = 1'b1;
        press_color_i = 2'(c);
        cyc();
        press_valid_i = 1'b0;
    endtask

    initial begin
        int n;
        int c;
        bit done;

        // Reset state
        #1;
        chk_idle_outputs("reset");
        chk("reset_len", len_o, 0);
        chk("reset_full", full_o, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Directed round: colours 1,2,3 then correct presses
        do_append(8'h05);
        do_append(8'hA2);
        do_append(8'h13);
        chk("dir_len", len_o, 3);
        play_and_check(1'b0);
        do_press(1);
        chk("dir_p1_ok", round_ok_o, 0);
        do_press(2);
        chk("dir_p2_checking", checking_o, 1);
        do_press(3);
        chk("dir_ok_pulse", round_ok_o, 1);
        chk("dir_ok_busy", busy_o, 0);
        chk("dir_ok_err", error_o, 0);
        cyc();
        chk("dir_ok_one_pulse", round_ok_o, 0);

        // Wrong second press
        play_and_check(1'b0);
        do_press(1);
        do_press(3);
        chk("dir_err_pulse", error_o, 1);
        chk("dir_err_ok", round_ok_o, 0);
        chk("dir_err_busy", busy_o, 0);
        chk("dir_err_len", len_o, 3);
        cyc();
        chk("dir_err_one_pulse", error_o, 0);

        // Randomized rounds, with appends attempted while busy
        for (int r = 0; r < 8; r++) begin
            do_clear();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) do_append(8'($urandom));
            chk("rnd_len", len_o, n);
            play_and_check(1'b1);
            done = 1'b0;
            for (int i = 0; i < n && !done; i++) begin
                for (int g = $urandom_range(0, 3); g > 0; g--) begin
                    cyc();
                    chk("rnd_gap_checking", checking_o, 1);
                    chk("rnd_gap_pulse", round_ok_o | error_o, 0);
                end
                c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : seq_q[i];
                do_press(c);
                if (c != seq_q[i]) begin
                    chk("rnd_err", error_o, 1);
                    chk("rnd_err_busy", busy_o, 0);
                    done = 1'b1;
                end else if (i == n - 1) begin
                    chk("rnd_ok", round_ok_o, 1);
                    chk("rnd_ok_busy", busy_o, 0);
                end else begin
                    chk("rnd_mid_pulse", round_ok_o | error_o, 0);
                    chk("rnd_mid_checking", checking_o, 1);
                end
            end
            chk("rnd_len_kept", len_o, n);
        end

        // Asynchronous reset in the middle of PLAY_ON
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();
        chk("pre_rst_valid", color_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_len", len_o, 0);
        chk("midrst_color", color_o, 0);
        cyc();
        rst_n = 1'b1;
        seq_q.delete();
        cyc();
        chk_idle_outputs("post_rst");

        // Fill beyond capacity: 33rd append dropped
        for (int i = 0; i < MAXL + 1; i++) begin
            do_append(8'($urandom));
            chk("fill_full", full_o, (i >= MAXL - 1));
        end
        chk("fill_len", len_o, MAXL);
        play_and_check(1'b0);
        do_clear();
        chk("clear_len", len_o, 0);
        chk("clear_full", full_o, 0);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        chk("start_empty_busy", busy_o, 0);

        // clear during CHECK
        do_append(8'h02);
        play_and_check(1'b0);
        do_clear();
        chk_idle_outputs("clr_check");
        chk("clr_check_len", len_o, 0);
        cyc();
        chk_idle_outputs("clr_check_after");

        // Idle in CHECK
        do_append(8'h07);
        play_and_check(1'b0);
`ifdef GENIUS_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT; i++) begin
            cyc();
            chk("tmo_wait_err", error_o, 0);
        end
        cyc();
        chk("tmo_err", error_o, 1);
        chk("tmo_flag", timeout_o, 1);
        chk("tmo_busy", busy_o, 0);
        chk("tmo_len", len_o, 1);
`else
        for (int i = 0; i < TIMEOUT + 16; i++) begin
            cyc();
            chk("notmo_err", error_o, 0);
            chk("notmo_flag", timeout_o, 0);
        end
        chk("notmo_checking", checking_o, 1);
`endif
        do_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
